// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: widths, RISC-V opcodes,
// FSM state encoding and the instruction-queue entry payload.
package instruction_fetcher_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              pred;
  } queue_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode.
// Ports: clk_in/rst_in (async active-low), en_in freezes all state when low,
// clr_in empties the queue, push_in/push_data_in write, pop_in requests a pop
// (ignored when empty), full_c/valid_c status, head_c is the combinational
// head entry (zero when empty).
module inst_queue
  import instruction_fetcher_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en_in,
  input  logic         clr_in,
  input  logic         push_in,
  input  queue_entry_t push_data_in,
  input  logic         pop_in,
  output logic         full_c,
  output logic         valid_c,
  output queue_entry_t head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  queue_entry_t     mem_q [DEPTH];
  queue_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign valid_c = (cnt_q != '0);
  assign full_c  = (cnt_q == CNT_W'(DEPTH));
  // Masking with valid keeps the head fields at zero while empty or in reset.
  assign head_c  = valid_c ? mem_q[rd_q] : '0;

  // Pointer/count update; clear wins, pointers wrap naturally (power-of-two depth).
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    push_ok = push_in && !full_c;
    pop_ok  = pop_in && valid_c;
    if (clr_in) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = push_data_in;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_d = rd_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_in) begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: issues one cache request at a time, predicts the next
// PC (JAL taken, backward branches taken) and queues fetched words for decode.
// Ports: clk_in, rst_in (async active-low), rdy_in (global freeze);
// RoB_clear/clear_pc redirect; i_waiting/i_addr request, i_result/i_m_ready
// response; inst_valid/inst/inst_pc/inst_pred queue head, dec_ready pop.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0,
  parameter int unsigned       QUEUE_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              RoB_clear,
  input  logic [ADDR_W-1:0] clear_pc,
  output logic              i_waiting,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [INST_W-1:0] i_result,
  input  logic              i_m_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_pred,
  input  logic              dec_ready
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              i_waiting_q, i_waiting_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;

  logic [6:0]        opcode;
  logic [ADDR_W-1:0] imm_j;
  logic [ADDR_W-1:0] imm_b;
  logic [ADDR_W-1:0] next_pc;
  logic              pred;
  logic              push_c;
  logic              q_full;
  queue_entry_t      push_data;
  queue_entry_t      head;

  assign i_waiting  = i_waiting_q;
  assign i_addr     = i_addr_q;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_pred  = head.pred;

  assign push_data.inst = i_result;
  assign push_data.pc   = pc_q;
  assign push_data.pred = pred;

  // Static predictor on the returned word: JAL always, branches only backward.
  always_comb begin
    opcode  = i_result[6:0];
    imm_j   = {{11{i_result[31]}}, i_result[31], i_result[19:12], i_result[20],
               i_result[30:21], 1'b0};
    imm_b   = {{19{i_result[31]}}, i_result[31], i_result[7], i_result[30:25],
               i_result[11:8], 1'b0};
    next_pc = pc_q + ADDR_W'(4);
    pred    = 1'b0;
    if (opcode == OP_JAL) begin
      next_pc = pc_q + imm_j;
      pred    = 1'b1;
    end else if ((opcode == OP_BRANCH) && imm_b[ADDR_W-1]) begin
      next_pc = pc_q + imm_b;
      pred    = 1'b1;
    end
  end

  // Fetch FSM; a redirect drops any in-flight response.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    i_waiting_d = i_waiting_q;
    i_addr_d    = i_addr_q;
    push_c      = 1'b0;
    if (RoB_clear) begin
      state_d     = ST_IDLE;
      pc_d        = clear_pc;
      i_waiting_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!q_full) begin
            state_d     = ST_FETCH;
            i_waiting_d = 1'b1;
            i_addr_d    = pc_q;
          end
        end
        ST_FETCH: begin
          if (i_m_ready) begin
            push_c      = 1'b1;
            pc_d        = next_pc;
            i_waiting_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      i_waiting_q <= 1'b0;
      i_addr_q    <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      i_waiting_q <= i_waiting_d;
      i_addr_q    <= i_addr_d;
    end
  end

  inst_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_inst_queue (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en_in       (rdy_in),
    .clr_in      (RoB_clear),
    .push_in     (push_c),
    .push_data_in(push_data),
    .pop_in      (dec_ready),
    .full_c      (q_full),
    .valid_c     (inst_valid),
    .head_c      (head)
  );

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: sequential fetch, JAL/branch
// prediction, queue-full back-pressure, redirect priority, freeze and reset.
module tb_instruction_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        RoB_clear;
  logic [31:0] clear_pc;
  logic        i_waiting;
  logic [31:0] i_addr;
  logic [31:0] i_result;
  logic        i_m_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred;
  logic        dec_ready;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_in = ~clk_in;

  instruction_fetcher #(
    .RESET_PC   (32'h0),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .RoB_clear (RoB_clear),
    .clear_pc  (clear_pc),
    .i_waiting (i_waiting),
    .i_addr    (i_addr),
    .i_result  (i_result),
    .i_m_ready (i_m_ready),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_pred (inst_pred),
    .dec_ready (dec_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bounded wait for a fetch request, sampled on negedges.
  task automatic wait_req();
    int i = 0;
    while (!i_waiting && i < 40) begin
      @(negedge clk_in);
      i++;
    end
    chk("req_seen", 32'(i_waiting), 32'd1);
  endtask

  // Answer one request one cycle after it is seen; optionally check the new head.
  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] word,
                       input logic exp_pred, input logic check_head);
    wait_req();
    chk("req_addr", i_addr, exp_addr);
    @(negedge clk_in);
    chk("addr_stable", i_addr, exp_addr);
    i_m_ready = 1'b1;
    i_result  = word;
    @(negedge clk_in);
    i_m_ready = 1'b0;
    chk("wait_drop", 32'(i_waiting), 32'd0);
    if (check_head) begin
      chk("head_valid", 32'(inst_valid), 32'd1);
      chk("head_pc", inst_pc, exp_addr);
      chk("head_inst", inst, word);
      chk("head_pred", 32'(inst_pred), 32'(exp_pred));
    end
  endtask

  task automatic pulse_clear(input logic [31:0] target);
    RoB_clear = 1'b1;
    clear_pc  = target;
    @(negedge clk_in);
    RoB_clear = 1'b0;
    chk("clr_wait", 32'(i_waiting), 32'd0);
    chk("clr_valid", 32'(inst_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; RoB_clear = 1'b0; clear_pc = '0;
    i_result = '0; i_m_ready = 1'b0; dec_ready = 1'b1;
    repeat (3) @(negedge clk_in);

    // Reset state
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_pred", 32'(inst_pred), 32'd0);
    chk("rst_wait", 32'(i_waiting), 32'd0);
    chk("rst_addr", i_addr, 32'd0);
    rst_in = 1'b1;

    // Straight-line fetch
    serve(32'h0, 32'h00000013, 1'b0, 1'b1);
    serve(32'h4, 32'h00000013, 1'b0, 1'b1);
    serve(32'h8, 32'h00000013, 1'b0, 1'b1);

    // JAL -8 at 0x100
    pulse_clear(32'h100);
    serve(32'h100, 32'hFF9FF0EF, 1'b1, 1'b1);
    serve(32'hF8,  32'h00000013, 1'b0, 1'b1);

    // Backward beq -4 at 0x200
    pulse_clear(32'h200);
    serve(32'h200, 32'hFE000EE3, 1'b1, 1'b1);
    serve(32'h1FC, 32'h00000013, 1'b0, 1'b1);

    // Forward beq +8 at 0x200 is not taken
    pulse_clear(32'h200);
    serve(32'h200, 32'h00000463, 1'b0, 1'b1);
    serve(32'h204, 32'h00000013, 1'b0, 1'b1);

    // Back-pressure: four pushes fill the queue
    dec_ready = 1'b0;
    pulse_clear(32'h300);
    for (int k = 0; k < 4; k++) begin
      serve(32'h300 + 32'(4 * k), 32'h00000013, 1'b0, 1'b0);
    end
    repeat (6) @(negedge clk_in);
    chk("full_no_req", 32'(i_waiting), 32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_head", inst_pc, 32'h300);
    dec_ready = 1'b1;
    @(negedge clk_in);
    dec_ready = 1'b0;
    chk("pop_head", inst_pc, 32'h304);
    serve(32'h310, 32'h00000013, 1'b0, 1'b0);
    repeat (6) @(negedge clk_in);
    chk("refull_no_req", 32'(i_waiting), 32'd0);

    // Redirect in the same cycle as a response
    dec_ready = 1'b1;
    pulse_clear(32'h400);
    wait_req();
    chk("pre_clr_addr", i_addr, 32'h400);
    i_m_ready = 1'b1; i_result = 32'h00000013; RoB_clear = 1'b1; clear_pc = 32'h80;
    @(negedge clk_in);
    i_m_ready = 1'b0; RoB_clear = 1'b0;
    chk("clr_drop_valid", 32'(inst_valid), 32'd0);
    chk("clr_drop_wait", 32'(i_waiting), 32'd0);
    serve(32'h80, 32'h00000013, 1'b0, 1'b1);

    // Freeze mid-fetch with a pending response and an ignored redirect
    wait_req();
    chk("frz_addr", i_addr, 32'h84);
    rdy_in = 1'b0; i_m_ready = 1'b1; i_result = 32'h00000013;
    RoB_clear = 1'b1; clear_pc = 32'h500;
    repeat (3) begin
      @(negedge clk_in);
      chk("frz_wait", 32'(i_waiting), 32'd1);
      chk("frz_valid", 32'(inst_valid), 32'd0);
      chk("frz_hold_addr", i_addr, 32'h84);
    end
    rdy_in = 1'b1; RoB_clear = 1'b0;
    @(negedge clk_in);
    i_m_ready = 1'b0;
    chk("resume_valid", 32'(inst_valid), 32'd1);
    chk("resume_pc", inst_pc, 32'h84);
    chk("resume_wait", 32'(i_waiting), 32'd0);

    // Reset in the middle of a fetch
    wait_req();
    chk("pre_rst_addr", i_addr, 32'h88);
    rst_in = 1'b0;
    #1;
    chk("arst_wait", 32'(i_waiting), 32'd0);
    chk("arst_addr", i_addr, 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    serve(32'h0, 32'h00000013, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, meaning the fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4 (power of two, 2..16), meaning the instruction queue entry count.
REQ-003 SHALL have ports: clk_in  in  1  system clock; rst_in  in  1  reset, asynchronous, active-low; rdy_in  in  1  global enable, freeze all state when low.
REQ-004 SHALL have ports: RoB_clear  in  1  flush/redirect; clear_pc  in  32  redirect target.
REQ-005 SHALL have ports: i_waiting  out  1  fetch request to cache; i_addr  out  32  fetch address; i_result  in  32  fetched word; i_m_ready  in  1  cache response valid.
REQ-006 SHALL have ports: inst_valid  out  1  queue head valid; inst  out  32  head instruction; inst_pc  out  32  head PC; inst_pred  out  1  head predicted-taken; dec_ready  in  1  decoder accepts head.

Function
REQ-007 SHALL hold a 32-bit pc register and a two-state FSM: IDLE, FETCH.
REQ-008 IDLE->FETCH when the queue is not full at the clock edge; i_waiting<=1 and i_addr<=pc on that edge.
REQ-009 In FETCH, i_waiting and i_addr SHALL stay stable until a cycle with i_m_ready=1 (cache matches on i_addr).
REQ-010 On i_m_ready=1 in FETCH: push {i_result, pc, pred}; pc<=next_pc; i_waiting<=0; FETCH->IDLE.
REQ-011 next_pc SHALL be pc+imm_J with pred=1 for opcode 1101111 (JAL).
REQ-012 next_pc SHALL be pc+imm_B with pred=1 for opcode 1100011 when imm_B is negative; otherwise pc+4 with pred=0.
REQ-013 next_pc SHALL be pc+4 with pred=0 for all other opcodes, JALR included.
REQ-014 Immediates SHALL be sign-extended to 32 bits; PC adds wrap modulo 2^32.
REQ-015 Queue SHALL be a circular FIFO with read/write pointers and a count of width clog2(QUEUE_DEPTH)+1.
REQ-016 inst_valid=(count!=0); head fields SHALL be driven combinationally from the read pointer.
REQ-017 Pop occurs when inst_valid && dec_ready; push and pop in one cycle SHALL leave count unchanged.
REQ-018 Pop from an empty queue SHALL be ignored; push never occurs when full (REQ-008 gates issue).
REQ-019 Pointers SHALL wrap from QUEUE_DEPTH-1 to 0.
REQ-020 RoB_clear=1 SHALL have priority over every other event in the same cycle.
REQ-021 On RoB_clear=1, next edge: pc<=clear_pc; count, pointers<=0; FSM<=IDLE; i_waiting<=0; any in-flight response discarded, even if i_m_ready=1 that cycle.
REQ-022 First fetch after a clear SHALL issue no earlier than the cycle after the clear edge.
REQ-023 With rdy_in=0 and no reset, no register SHALL change; RoB_clear SHALL also be ignored.

Reset
REQ-024 rst_in=0 SHALL asynchronously set pc=RESET_PC, FSM=IDLE, count and pointers=0, i_waiting=0, i_addr=0.
REQ-025 During reset, outputs SHALL be inst_valid=0, inst=0, inst_pc=0, inst_pred=0.
REQ-026 Reset mid-FETCH SHALL abandon the request; the first request after release SHALL target RESET_PC.

Structure
REQ-027 A shared package SHALL hold opcode constants (OP_JAL=7'b1101111, OP_BRANCH=7'b1100011) and the 32-bit address width constant.
REQ-028 The FIFO SHALL be one sub-module named inst_queue; the predecessor/next_pc logic SHALL stay in instruction_fetcher.

Verification
REQ-029 After reset release, cache responds with 32'h00000013 (addi) 2 cycles after each request, dec_ready=1 -> i_addr sequence 0,4,8; inst_pc follows; inst_pred=0.
REQ-030 At pc=32'h100, response 32'hFF9FF0EF (jal -8) -> next i_addr=32'hF8, inst_pred=1.
REQ-031 At pc=32'h200, response 32'hFE000EE3 (beq backward -4) -> next i_addr=32'h1FC, pred=1; forward beq -> 32'h204, pred=0.
REQ-032 dec_ready=0, QUEUE_DEPTH=4 -> exactly 4 pushes, then i_waiting stays 0; one pop -> exactly one further request.
REQ-033 RoB_clear=1 with clear_pc=32'h80 in the same cycle as i_m_ready=1 -> no push, inst_valid=0 next cycle, next i_addr=32'h80.
REQ-034 rdy_in=0 for 3 cycles mid-FETCH with i_m_ready=1 -> no state change; resumes and completes on the first rdy_in=1 cycle.
